simd_decoder: RTL and testbench
===============================

// Module: simd_decoder
// PURPOSE
//  Instruction decoder and program counter for the SIMD processor.
//  - Splits each instruction word into operand/result vector-register addresses and control strobes.
//  - These drive the PE array, the dot-product reducer, the shift unit and the register-file write port.
//  - Issues one instruction per two-clk slot, paced by the half_clk phase signal.
// PARAMETERS
//  INS_ADDR_WIDTH  10  width of pc (instruction memory depth 2**INS_ADDR_WIDTH)
//  ADDR_WIDTH      10  width of each register-file address field
//  DATA_WIDTH      32  datapath width; reserved, no logic depends on it
//  OPCODE_WIDTH    3   opcode field width
//  OP_SEL_WIDTH    2   PE operation-select width
// PORTS
//  clk          in   1                     single system clock, rising edge
//  rstn         in   1                     synchronous reset, ACTIVE-HIGH (1 = reset); name kept for codebase compatibility
//  half_clk     in   1                     slot-phase level sampled on clk: 0 = read phase, 1 = write phase; not a clock
//  instruction  in   OPCODE_WIDTH+3*ADDR_WIDTH  {opcode, a, b, r}, MSB first
//  pc           out  INS_ADDR_WIDTH        instruction fetch address
//  a_addr       out  ADDR_WIDTH            operand A register address
//  b_addr       out  ADDR_WIDTH            operand B register address
//  pe_op        out  OP_SEL_WIDTH          PE op: 00 add, 01 sub, 10 mul, 11 pass-A
//  dot_prod_en  out  1                     enable dot-product reduction
//  shift        out  1                     enable vector shift of operand A
//  r_addr       out  ADDR_WIDTH            result register address
//  write_en     out  1                     register-file write strobe
//  r_select     out  1                     write-back source: 0 = PE vector, 1 = reducer scalar
// BEHAVIOUR
//  - Field slices with default widths:
//    - opcode = instruction[32:30]
//    - a = [29:20]
//    - b = [19:10]
//    - r = [9:0]
//  - All outputs are registered and update only on rising clk.
//  - Reset: while rstn=1 at a clk edge, every output and the halted flag clear to 0. Reset has priority over everything.
//  - Field/strobe latency: a_addr, b_addr, r_addr, pe_op, dot_prod_en, shift and r_select reflect the instruction sampled at the previous clk edge. They update every edge.
//  - Opcode table (pe_op / dot_prod_en / shift / r_select / writes):
//    - 000 NOP:   00/0/0/0/no
//    - 001 ADD:   00/0/0/0/yes
//    - 010 SUB:   01/0/0/0/yes
//    - 011 MUL:   10/0/0/0/yes
//    - 100 DOT:   10/1/0/1/yes
//    - 101 SHIFT: 11/0/1/0/yes
//    - 110 reserved: decodes as NOP
//    - 111 HALT:  decodes as NOP and sets halted
//  - Address outputs always carry the raw fields, including for NOP and HALT.
//  - write_en: 1 for exactly one clk, at the edge where half_clk=1 is sampled, the opcode is a writing opcode, and halted=0. Otherwise 0.
//  - pc: +1 at each edge where half_clk=1 is sampled and halted=0. pc wraps from all-ones to 0 with no flag.
//  - HALT: halted is set at the edge that samples opcode 111 with half_clk=1.
//    - halted is sticky until reset; pc freezes and write_en stays 0.
//  - Decode and pc in the same edge: the new decode and the pc increment happen together, with no stall.
//  - Reset mid-slot: the pending write is dropped; after release pc restarts at 0.
// TESTING
//  - Reset: rstn=1 for 2 clk -> all outputs 0; release -> pc increments once per half_clk period (0,1,2...).
//  - Instr {001,5,10,15} -> a=5, b=10, r=15, pe_op=00, write_en pulses 1 clk during half_clk=1, r_select=0.
//  - Instr {100,50,55,60} -> dot_prod_en=1, pe_op=10, r_select=1, write_en pulse.
//  - Instr {101,50,55,60} -> shift=1, pe_op=11; then {000,...} -> write_en never asserts; pc still advances.
//  - Instr {111,...} with half_clk=1 -> pc frozen and write_en 0 for 10 slots; rstn=1 -> pc=0, normal resume.
//  - Preload pc to 1023 via 1023 slots -> next slot pc=0; reset asserted during half_clk=1 -> no write_en.

Source files
------------

// File: rtl/simd_decoder.sv
// Instruction decoder and program counter for the SIMD processor.
// Splits each instruction word {opcode, a, b, r} into register addresses and
// control strobes, and advances pc once per two-clk slot. Every output is
// registered.
// Ports:
//   clk          system clock, rising edge
//   rstn         synchronous reset, active-high (1 = reset)
//   half_clk     slot phase level: 0 = read phase, 1 = write phase
//   instruction  {opcode, a, b, r}, MSB first
//   pc           instruction fetch address
//   a_addr       operand A register address
//   b_addr       operand B register address
//   pe_op        PE op: 00 add, 01 sub, 10 mul, 11 pass-A
//   dot_prod_en  dot-product reduction enable
//   shift        vector shift enable for operand A
//   r_addr       result register address
//   write_en     register-file write strobe, one clk per writing slot
//   r_select     write-back source: 0 = PE vector, 1 = reducer scalar
module simd_decoder #(
   parameter int unsigned INS_ADDR_WIDTH = 10,
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned OPCODE_WIDTH   = 3,
   parameter int unsigned OP_SEL_WIDTH   = 2
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 half_clk,
   input  logic [OPCODE_WIDTH+3*ADDR_WIDTH-1:0] instruction,
   output logic [INS_ADDR_WIDTH-1:0]            pc,
   output logic [ADDR_WIDTH-1:0]                a_addr,
   output logic [ADDR_WIDTH-1:0]                b_addr,
   output logic [OP_SEL_WIDTH-1:0]              pe_op,
   output logic                                 dot_prod_en,
   output logic                                 shift,
   output logic [ADDR_WIDTH-1:0]                r_addr,
   output logic                                 write_en,
   output logic                                 r_select
);

   localparam int unsigned InsWidth = OPCODE_WIDTH + 3 * ADDR_WIDTH;

   localparam logic [OPCODE_WIDTH-1:0] OpAdd   = OPCODE_WIDTH'(3'b001);
   localparam logic [OPCODE_WIDTH-1:0] OpSub   = OPCODE_WIDTH'(3'b010);
   localparam logic [OPCODE_WIDTH-1:0] OpMul   = OPCODE_WIDTH'(3'b011);
   localparam logic [OPCODE_WIDTH-1:0] OpDot   = OPCODE_WIDTH'(3'b100);
   localparam logic [OPCODE_WIDTH-1:0] OpShift = OPCODE_WIDTH'(3'b101);
   localparam logic [OPCODE_WIDTH-1:0] OpHalt  = OPCODE_WIDTH'(3'b111);

   // The opcode table needs 3 opcode bits and 2 op-select bits; the datapath
   // width is carried for interface compatibility only.
   if (OPCODE_WIDTH < 3) begin : g_bad_opcode_width
      $error("simd_decoder: OPCODE_WIDTH must be at least 3");
   end
   if (OP_SEL_WIDTH < 2) begin : g_bad_op_sel_width
      $error("simd_decoder: OP_SEL_WIDTH must be at least 2");
   end
   if (DATA_WIDTH == 0) begin : g_bad_data_width
      $error("simd_decoder: DATA_WIDTH must be non-zero");
   end

   logic [OPCODE_WIDTH-1:0]   opcode_c;
   logic [ADDR_WIDTH-1:0]     a_field_c;
   logic [ADDR_WIDTH-1:0]     b_field_c;
   logic [ADDR_WIDTH-1:0]     r_field_c;

   logic [INS_ADDR_WIDTH-1:0] pc_q,    pc_d;
   logic [ADDR_WIDTH-1:0]     a_q,     a_d;
   logic [ADDR_WIDTH-1:0]     b_q,     b_d;
   logic [ADDR_WIDTH-1:0]     r_q,     r_d;
   logic [OP_SEL_WIDTH-1:0]   pe_op_q, pe_op_d;
   logic                      dot_q,   dot_d;
   logic                      shift_q, shift_d;
   logic                      rsel_q,  rsel_d;
   logic                      wen_q,   wen_d;
   logic                      halted_q, halted_d;
   logic                      writes_c;

   // Field split of the instruction word.
   assign opcode_c  = instruction[InsWidth-1 -: OPCODE_WIDTH];
   assign a_field_c = instruction[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
   assign b_field_c = instruction[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
   assign r_field_c = instruction[ADDR_WIDTH-1:0];

   // Decode, write strobe, pc advance and halt tracking for the next edge.
   always_comb begin
      a_d      = a_field_c;
      b_d      = b_field_c;
      r_d      = r_field_c;
      pe_op_d  = '0;
      dot_d    = 1'b0;
      shift_d  = 1'b0;
      rsel_d   = 1'b0;
      writes_c = 1'b0;
      pc_d     = pc_q;
      halted_d = halted_q;

      unique case (opcode_c)
         OpAdd:   writes_c = 1'b1;
         OpSub:   begin pe_op_d = OP_SEL_WIDTH'(2'b01); writes_c = 1'b1; end
         OpMul:   begin pe_op_d = OP_SEL_WIDTH'(2'b10); writes_c = 1'b1; end
         OpDot:   begin
            pe_op_d  = OP_SEL_WIDTH'(2'b10);
            dot_d    = 1'b1;
            rsel_d   = 1'b1;
            writes_c = 1'b1;
         end
         OpShift: begin
            pe_op_d  = OP_SEL_WIDTH'(2'b11);
            shift_d  = 1'b1;
            writes_c = 1'b1;
         end
         default: ;  // NOP, reserved and HALT decode as no-ops
      endcase

      // Halted state is the value before this edge: the HALT slot itself still
      // advances pc once, then everything freezes.
      wen_d = half_clk && writes_c && !halted_q;
      if (half_clk && !halted_q) begin
         pc_d = pc_q + INS_ADDR_WIDTH'(1);
      end
      if (half_clk && (opcode_c == OpHalt)) begin
         halted_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         pc_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         pe_op_q  <= '0;
         dot_q    <= 1'b0;
         shift_q  <= 1'b0;
         rsel_q   <= 1'b0;
         wen_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         r_q      <= r_d;
         pe_op_q  <= pe_op_d;
         dot_q    <= dot_d;
         shift_q  <= shift_d;
         rsel_q   <= rsel_d;
         wen_q    <= wen_d;
         halted_q <= halted_d;
      end
   end

   assign pc          = pc_q;
   assign a_addr      = a_q;
   assign b_addr      = b_q;
   assign r_addr      = r_q;
   assign pe_op       = pe_op_q;
   assign dot_prod_en = dot_q;
   assign shift       = shift_q;
   assign r_select    = rsel_q;
   assign write_en    = wen_q;

endmodule

// File: tb/tb_simd_decoder.sv
// Self-checking bench for simd_decoder: directed slots from the block's test
// list plus randomized traffic, compared against a table-driven model.
module tb_simd_decoder;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        half_clk = 1'b0;
   logic [32:0] instruction = '0;
   logic [9:0]  pc;
   logic [9:0]  a_addr;
   logic [9:0]  b_addr;
   logic [1:0]  pe_op;
   logic        dot_prod_en;
   logic        shift;
   logic [9:0]  r_addr;
   logic        write_en;
   logic        r_select;

   int total = 0;
   int bad   = 0;

   // Reference state: what the outputs should read after the latest edge.
   int m_pc = 0, m_a = 0, m_b = 0, m_r = 0, m_pe = 0;
   int m_dot = 0, m_shift = 0, m_rsel = 0, m_wen = 0;
   bit m_halted = 1'b0;

   // Opcode table, indexed by opcode: pe_op, dot, shift, r_select, writes.
   int pe_tab[8]    = '{0, 0, 1, 2, 2, 3, 0, 0};
   int dot_tab[8]   = '{0, 0, 0, 0, 1, 0, 0, 0};
   int shf_tab[8]   = '{0, 0, 0, 0, 0, 1, 0, 0};
   int rsel_tab[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
   int wr_tab[8]    = '{0, 1, 1, 1, 1, 1, 0, 0};

   simd_decoder dut (
      .clk         (clk),
      .rstn        (rstn),
      .half_clk    (half_clk),
      .instruction (instruction),
      .pc          (pc),
      .a_addr      (a_addr),
      .b_addr      (b_addr),
      .pe_op       (pe_op),
      .dot_prod_en (dot_prod_en),
      .shift       (shift),
      .r_addr      (r_addr),
      .write_en    (write_en),
      .r_select    (r_select)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [32:0] mk(input int op, input int a, input int b, input int r);
      return {3'(op), 10'(a), 10'(b), 10'(r)};
   endfunction

   // Model of one clk edge, written straight from the behavioural rules.
   task automatic model_edge(input bit rst, input bit hc, input logic [32:0] ins);
      int op;
      op = int'(ins[32:30]);
      if (rst) begin
         m_pc = 0; m_a = 0; m_b = 0; m_r = 0; m_pe = 0;
         m_dot = 0; m_shift = 0; m_rsel = 0; m_wen = 0; m_halted = 1'b0;
      end else begin
         m_a     = int'(ins[29:20]);
         m_b     = int'(ins[19:10]);
         m_r     = int'(ins[9:0]);
         m_pe    = pe_tab[op];
         m_dot   = dot_tab[op];
         m_shift = shf_tab[op];
         m_rsel  = rsel_tab[op];
         m_wen   = (hc && wr_tab[op] == 1 && !m_halted) ? 1 : 0;
         if (hc && !m_halted) m_pc = (m_pc + 1) % 1024;
         if (hc && op == 7) m_halted = 1'b1;
      end
   endtask

   task automatic check_all();
      check("pc",       int'(pc),          m_pc);
      check("a_addr",   int'(a_addr),      m_a);
      check("b_addr",   int'(b_addr),      m_b);
      check("r_addr",   int'(r_addr),      m_r);
      check("pe_op",    int'(pe_op),       m_pe);
      check("dot",      int'(dot_prod_en), m_dot);
      check("shift",    int'(shift),       m_shift);
      check("r_select", int'(r_select),    m_rsel);
      check("write_en", int'(write_en),    m_wen);
   endtask

   // Drive one clk: inputs on the falling edge, outputs sampled 1 after rising.
   task automatic step(input bit rst, input bit hc, input logic [32:0] ins);
      @(negedge clk);
      rstn        = rst;
      half_clk    = hc;
      instruction = ins;
      @(posedge clk);
      model_edge(rst, hc, ins);
      #1;
      check_all();
   endtask

   // One slot: read phase then write phase with the same instruction.
   task automatic slot(input logic [32:0] ins);
      step(1'b0, 1'b0, ins);
      step(1'b0, 1'b1, ins);
   endtask

   function automatic logic [32:0] rand_ins(input bit allow_halt);
      int op;
      op = int'($urandom_range(0, 7));
      if (!allow_halt && op == 7) op = 1;
      return mk(op, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                int'($urandom_range(0, 1023)));
   endfunction

   initial begin
      // Reset held for two clocks.
      step(1'b1, 1'b0, mk(1, 5, 10, 15));
      step(1'b1, 1'b1, mk(4, 50, 55, 60));
      check("pc_after_reset", int'(pc), 0);

      // pc counts once per slot from 0.
      for (int i = 0; i < 3; i++) slot(mk(0, i, i, i));
      check("pc_count", int'(pc), 3);

      // Directed opcodes from the test list.
      slot(mk(1, 5, 10, 15));
      slot(mk(4, 50, 55, 60));
      slot(mk(5, 50, 55, 60));
      slot(mk(0, 50, 55, 60));
      slot(mk(2, 1, 2, 3));
      slot(mk(3, 4, 5, 6));
      slot(mk(6, 7, 8, 9));

      // HALT: pc and write_en frozen for ten slots of writing instructions.
      slot(mk(7, 11, 12, 13));
      for (int i = 0; i < 10; i++) slot(rand_ins(1'b0));
      check("pc_frozen", int'(pc), 11);

      // Reset releases the halt and restarts pc at 0.
      step(1'b1, 1'b0, mk(1, 1, 1, 1));
      for (int i = 0; i < 2; i++) slot(mk(1, i, i, i));

      // Run pc to all-ones and across the wrap.
      for (int i = 0; i < 1030; i++) slot(rand_ins(1'b0));
      check("pc_wrapped", int'(pc), 8);

      // Reset in the write phase of a writing slot drops the write.
      step(1'b0, 1'b0, mk(1, 2, 3, 4));
      step(1'b1, 1'b1, mk(1, 2, 3, 4));
      check("wen_dropped", int'(write_en), 0);

      // Random traffic: random phase, occasional HALT and reset.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) == 0), bit'($urandom_range(0, 1)),
              rand_ins($urandom_range(0, 19) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
